// File: rtl/core_run_pkg.sv
// Shared types for the core run controller: FSM states, run status codes, default halt word.
// Pure declarations; no timing or flow control of its own.
package core_run_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } runState_t;

  typedef enum logic [2:0] {
    ST_NONE    = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_STALL   = 3'd4
  } runStatus_t;

  // ebreak
  localparam logic [31:0] HALT_INST_DEFAULT = 32'h00100073;

  // A halting program reports success by leaving zero in a0.
  function automatic runStatus_t haltStatus(input logic [31:0] a0);
    return (a0 == '0) ? ST_PASS : ST_FAIL;
  endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// Bench-top <-> run controller bundle: run control, commit stream in, status/counters out.
// Plain level/strobe signals; no handshake, so the controller never backpressures.
interface core_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             go;
  logic             clear;
  logic             commit;
  logic [31:0]      commit_pc;
  logic [31:0]      commit_inst;
  logic [31:0]      reg_a0;

  logic             start;
  logic             running;
  logic             done;
  logic [2:0]       status;
  logic [31:0]      exit_code;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;
  logic [31:0]      last_pc;

  modport master (
    output go, clear, commit, commit_pc, commit_inst, reg_a0,
    input  start, running, done, status, exit_code, cycle_cnt, instret_cnt, last_pc
  );

  modport slave (
    input  go, clear, commit, commit_pc, commit_inst, reg_a0,
    output start, running, done, status, exit_code, cycle_cnt, instret_cnt, last_pc
  );

endinterface

// File: rtl/core_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment); 1-cycle update.
// No backpressure: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Sequences a core under test: delayed start, commit monitoring, halt/timeout/stall end, latched results.
// Outputs registered (DONE/status visible the cycle after the ending event); inputs are never backpressured.
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int          START_DELAY    = 4,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          STALL_LIMIT    = 1024,
  parameter logic [31:0] HALT_INST      = HALT_INST_DEFAULT,
  parameter int          CNT_W          = 32
) (
  input logic           clock,
  input logic           reset,
  core_run_ctrl_if.slave bus
);

  localparam int DLY_W   = $clog2(START_DELAY + 1);
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  localparam logic [DLY_W-1:0]   DLY_LOAD     = DLY_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST   = STALL_W'(STALL_LIMIT - 1);

  runState_t          state;
  runStatus_t         statusQ;
  logic [DLY_W-1:0]   delayCnt;
  logic               startQ;
  logic               runningQ;
  logic               doneQ;
  logic [31:0]        exitCodeQ;
  logic [31:0]        lastPcQ;

  logic [CNT_W-1:0]   cycleCnt;
  logic [CNT_W-1:0]   instretCnt;
  logic [STALL_W-1:0] stallCnt;

  logic inRun;
  logic runCommit;
  logic haltHit;
  logic timeoutHit;
  logic stallHit;
  logic endHit;
  logic clearHit;

  assign inRun      = (state == S_RUN);
  assign runCommit  = inRun && bus.commit;
  assign haltHit    = runCommit && (bus.commit_inst == HALT_INST);
  assign timeoutHit = inRun && (cycleCnt == TIMEOUT_LAST);
  // A commit cycle is by definition not a stall, so halt always beats stall.
  assign stallHit   = inRun && !bus.commit && (stallCnt == STALL_LAST);
  assign endHit     = haltHit || timeoutHit || stallHit;
  assign clearHit   = (state == S_DONE) && bus.clear;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      delayCnt  <= '0;
      startQ    <= 1'b0;
      runningQ  <= 1'b0;
      doneQ     <= 1'b0;
      statusQ   <= ST_NONE;
      exitCodeQ <= '0;
      lastPcQ   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.go) begin
            state    <= S_WAIT;
            delayCnt <= DLY_LOAD;
          end
        end

        S_WAIT: begin
          if (delayCnt == '0) begin
            state    <= S_RUN;
            startQ   <= 1'b1;
            runningQ <= 1'b1;
          end else begin
            delayCnt <= delayCnt - DLY_W'(1);
          end
        end

        S_RUN: begin
          if (bus.commit) begin
            lastPcQ <= bus.commit_pc;
          end
          if (endHit) begin
            state    <= S_DONE;
            startQ   <= 1'b0;
            runningQ <= 1'b0;
            doneQ    <= 1'b1;
          end
          if (haltHit) begin
            statusQ   <= haltStatus(bus.reg_a0);
            exitCodeQ <= bus.reg_a0;
          end else if (timeoutHit) begin
            statusQ <= ST_TIMEOUT;
          end else if (stallHit) begin
            statusQ <= ST_STALL;
          end
        end

        S_DONE: begin
          if (bus.clear) begin
            state     <= S_IDLE;
            doneQ     <= 1'b0;
            statusQ   <= ST_NONE;
            exitCodeQ <= '0;
            lastPcQ   <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) uCycleCnt (
    .clock (clock),
    .reset (reset),
    .inc   (inRun),
    .clr   (clearHit),
    .count (cycleCnt)
  );

  sat_counter #(.WIDTH(CNT_W)) uInstretCnt (
    .clock (clock),
    .reset (reset),
    .inc   (runCommit),
    .clr   (clearHit),
    .count (instretCnt)
  );

  // Held at zero outside RUN so every run starts with a fresh stall window.
  sat_counter #(.WIDTH(STALL_W)) uStallCnt (
    .clock (clock),
    .reset (reset),
    .inc   (inRun && !bus.commit),
    .clr   (!inRun || bus.commit),
    .count (stallCnt)
  );

  assign bus.start       = startQ;
  assign bus.running     = runningQ;
  assign bus.done        = doneQ;
  assign bus.status      = statusQ;
  assign bus.exit_code   = exitCodeQ;
  assign bus.cycle_cnt   = cycleCnt;
  assign bus.instret_cnt = instretCnt;
  assign bus.last_pc     = lastPcQ;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: start delay, halt pass/fail, timeout, stall, priorities, reset and clear.
module tb_core_run_ctrl;

  localparam logic [31:0] HALT = 32'h00100073;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic clock = 1'b0;
  logic reset;
  int   tests  = 0;
  int   failed = 0;

  always #5 clock = ~clock;

  core_run_ctrl_if #(.CNT_W(32)) bus ();

  core_run_ctrl #(
    .START_DELAY    (4),
    .TIMEOUT_CYCLES (50),
    .STALL_LIMIT    (8),
    .HALT_INST      (HALT),
    .CNT_W          (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // go pulse, then the 4-cycle delay; returns just after the first RUN edge.
  task automatic startRun();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    repeat (4) tick();
  endtask

  task automatic clearRun();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic drive(input logic c, input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] a0);
    bus.commit      = c;
    bus.commit_pc   = pc;
    bus.commit_inst = inst;
    bus.reg_a0      = a0;
  endtask

  initial begin
    reset = 1'b1;
    bus.go = 1'b0;
    bus.clear = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) tick();

    check("rst_start",   32'(bus.start),   32'd0);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    check("rst_status",  32'(bus.status),  32'd0);
    check("rst_exit",    bus.exit_code,    32'd0);
    check("rst_cycle",   bus.cycle_cnt,    32'd0);
    check("rst_instret", bus.instret_cnt,  32'd0);
    check("rst_lastpc",  bus.last_pc,      32'd0);

    reset = 1'b0;
    tick();

    // Start delay: start rises on the 4th edge after the IDLE->WAIT edge.
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    repeat (3) tick();
    check("wait_start",  32'(bus.start),  32'd0);
    check("wait_status", 32'(bus.status), 32'd0);
    check("wait_cycle",  bus.cycle_cnt,   32'd0);
    tick();
    check("run_start",   32'(bus.start),   32'd1);
    check("run_running", 32'(bus.running), 32'd1);
    check("run_cycle0",  bus.cycle_cnt,    32'd0);

    // 10 ordinary commits then a passing halt.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), NOP, 32'h0);
      tick();
    end
    drive(1'b1, 32'h128, HALT, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check("pass_done",    32'(bus.done),    32'd1);
    check("pass_status",  32'(bus.status),  32'd1);
    check("pass_exit",    bus.exit_code,    32'd0);
    check("pass_instret", bus.instret_cnt,  32'd11);
    check("pass_cycle",   bus.cycle_cnt,    32'd11);
    check("pass_lastpc",  bus.last_pc,      32'h128);
    check("pass_start",   32'(bus.start),   32'd0);
    check("pass_running", 32'(bus.running), 32'd0);

    // Commits and go are ignored in DONE.
    drive(1'b1, 32'h999, HALT, 32'h5);
    bus.go = 1'b1;
    repeat (2) tick();
    bus.go = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check("done_instret_hold", bus.instret_cnt, 32'd11);
    check("done_exit_hold",    bus.exit_code,   32'd0);
    check("done_lastpc_hold",  bus.last_pc,     32'h128);
    check("done_hold",         32'(bus.done),   32'd1);

    clearRun();
    check("clr_done",    32'(bus.done),   32'd0);
    check("clr_status",  32'(bus.status), 32'd0);
    check("clr_cycle",   bus.cycle_cnt,   32'd0);
    check("clr_instret", bus.instret_cnt, 32'd0);
    check("clr_lastpc",  bus.last_pc,     32'd0);

    // Halt commit while IDLE is ignored.
    drive(1'b1, 32'h300, HALT, 32'h7);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check("idle_instret", bus.instret_cnt, 32'd0);
    check("idle_done",    32'(bus.done),   32'd0);
    check("idle_lastpc",  bus.last_pc,     32'd0);

    // Failing halt.
    startRun();
    drive(1'b1, 32'h400, HALT, 32'h2A);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check("fail_status",  32'(bus.status), 32'd2);
    check("fail_exit",    bus.exit_code,   32'h2A);
    check("fail_instret", bus.instret_cnt, 32'd1);
    check("fail_cycle",   bus.cycle_cnt,   32'd1);
    clearRun();
    check("fail_clr_exit", bus.exit_code, 32'd0);

    // Timeout: commit on even RUN cycles, 50 RUN cycles total.
    startRun();
    for (int k = 0; k < 50; k++) begin
      drive((k % 2) == 0, 32'h200 + 32'(k), NOP, 32'h0);
      tick();
      if (k == 48) check("to_not_yet", 32'(bus.done), 32'd0);
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check("to_done",    32'(bus.done),   32'd1);
    check("to_status",  32'(bus.status), 32'd3);
    check("to_cycle",   bus.cycle_cnt,   32'd50);
    check("to_instret", bus.instret_cnt, 32'd25);
    check("to_lastpc",  bus.last_pc,     32'h230);
    check("to_exit",    bus.exit_code,   32'd0);
    clearRun();

    // Stall: two commits, then 8 idle RUN cycles.
    startRun();
    drive(1'b1, 32'h500, NOP, 32'h0);
    tick();
    drive(1'b1, 32'h504, NOP, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    repeat (7) tick();
    check("st_not_yet", 32'(bus.done), 32'd0);
    tick();
    check("st_done",    32'(bus.done),   32'd1);
    check("st_status",  32'(bus.status), 32'd4);
    check("st_cycle",   bus.cycle_cnt,   32'd10);
    check("st_instret", bus.instret_cnt, 32'd2);
    check("st_lastpc",  bus.last_pc,     32'h504);
    clearRun();

    // Halt on the cycle the stall limit is reached.
    startRun();
    repeat (7) tick();
    drive(1'b1, 32'h600, HALT, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check("hs_status",  32'(bus.status), 32'd1);
    check("hs_instret", bus.instret_cnt, 32'd1);
    check("hs_cycle",   bus.cycle_cnt,   32'd8);
    clearRun();

    // Halt on the 50th RUN cycle (timeout cycle).
    startRun();
    for (int k = 0; k < 49; k++) begin
      drive(1'b1, 32'h800 + 32'(4 * k), NOP, 32'h0);
      tick();
    end
    drive(1'b1, 32'h8C4, HALT, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check("ht_status",  32'(bus.status), 32'd1);
    check("ht_cycle",   bus.cycle_cnt,   32'd50);
    check("ht_instret", bus.instret_cnt, 32'd50);
    check("ht_lastpc",  bus.last_pc,     32'h8C4);
    clearRun();

    // clear ignored in RUN; then async reset mid-run.
    startRun();
    drive(1'b1, 32'h700, NOP, 32'h0);
    bus.clear = 1'b1;
    repeat (2) tick();
    bus.clear = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check("rc_running", 32'(bus.running), 32'd1);
    check("rc_instret", bus.instret_cnt,  32'd2);
    check("rc_cycle",   bus.cycle_cnt,    32'd2);

    #3;
    reset = 1'b1;
    #1;
    check("ar_start",   32'(bus.start),   32'd0);
    check("ar_running", 32'(bus.running), 32'd0);
    check("ar_cycle",   bus.cycle_cnt,    32'd0);
    tick();
    reset = 1'b0;
    check("ar_instret", bus.instret_cnt, 32'd0);
    check("ar_lastpc",  bus.last_pc,     32'd0);
    check("ar_status",  32'(bus.status), 32'd0);

    // Rerun from IDLE after reset with fresh counters.
    startRun();
    check("rr_start", 32'(bus.start), 32'd1);
    check("rr_cycle", bus.cycle_cnt,  32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA00 + 32'(4 * i), NOP, 32'h0);
      tick();
    end
    drive(1'b1, 32'hA0C, HALT, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check("rr_status",  32'(bus.status), 32'd1);
    check("rr_instret", bus.instret_cnt, 32'd4);
    check("rr_cycle",   bus.cycle_cnt,   32'd4);
    check("rr_lastpc",  bus.last_pc,     32'hA0C);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Simulation run controller that sequences the Core under test.
- After reset it waits a programmable delay, then drives the core's start input.
- It monitors the commit stream (commit/pc/inst) and architectural a0 (x10).
- It ends the run on a halt instruction, a global timeout or a commit stall, and latches pass/fail status, exit code and performance counters for the bench top.

Parameters:
START_DELAY, 4, cycles spent in WAIT before start is asserted (>=1)
TIMEOUT_CYCLES, 100000, max cycles in RUN before TIMEOUT
STALL_LIMIT, 1024, max consecutive RUN cycles without commit before STALL
HALT_INST, 32'h00100073, instruction word (ebreak) that ends the run
CNT_W, 32, width of cycle/instret counters

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
go  in  1  level; IDLE->WAIT when high
clear  in  1  pulse; DONE->IDLE
commit  in  1  core instState commit strobe
commit_pc  in  32  pc of committing instruction
commit_inst  in  32  instruction word of committing instruction
reg_a0  in  32  architectural x10 from intRegState
start  out  1  drives core io_in_start
running  out  1  high in RUN
done  out  1  high in DONE
status  out  3  0 NONE, 1 PASS, 2 FAIL, 3 TIMEOUT, 4 STALL
exit_code  out  32  a0 latched at halt; 0 otherwise
cycle_cnt  out  CNT_W  cycles spent in RUN
instret_cnt  out  CNT_W  commits counted in RUN, including the halt
last_pc  out  32  pc of most recent commit in RUN

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - All outputs 0: start, running, done, status=NONE, exit_code, counters, last_pc.
  - Reset mid-run drops start immediately, not at the next edge.
- FSM states: IDLE, WAIT, RUN, DONE.
  - IDLE: go=1 -> WAIT; delay counter loads START_DELAY-1.
  - WAIT: decrement each cycle; at 0 -> RUN. Entry to RUN occurs exactly START_DELAY cycles after the IDLE->WAIT edge.
  - RUN: start=1 and running=1, registered and both high from the first RUN cycle. cycle_cnt increments every RUN cycle. In a commit cycle, instret_cnt increments and last_pc<=commit_pc.
  - DONE: start=0, running=0, done=1. Counters, status and exit_code hold. clear=1 -> IDLE and zeroes counters, status, exit_code and last_pc. go is ignored in DONE.
- Termination, evaluated every RUN cycle in priority order:
  1. commit && commit_inst==HALT_INST: PASS if reg_a0==0, else FAIL; exit_code<=reg_a0 sampled that same cycle. The halt is counted in instret_cnt.
  2. cycle_cnt reaching TIMEOUT_CYCLES-1 (i.e. the TIMEOUT_CYCLES-th RUN cycle): TIMEOUT.
  3. Stall counter reaching STALL_LIMIT-1 with no commit: STALL.
  - DONE and status are visible on the cycle after the terminating event.
- Stall counter:
  - Cleared on any commit and on RUN entry.
  - Increments otherwise.
- Simultaneous events: a halt commit in the same cycle as timeout or stall yields PASS/FAIL (halt wins). Timeout beats stall.
- Counters saturate at all-ones; no wrap.
- commit outside RUN is ignored: no counting, no halt detection.
- go deasserting in WAIT does not abort.
- clear outside DONE is ignored.

Decomposition:
- Package core_run_pkg:
  - state enum (IDLE/WAIT/RUN/DONE)
  - status encodings (ST_NONE..ST_STALL)
  - default HALT_INST constant
- One sub-module, sat_counter (width parameter; inc, clr, saturating), instantiated for cycle_cnt, instret_cnt and the stall counter.
- FSM and termination logic stay in the top.

Test Plan:
- Reset, then go=1 for 1 cycle with START_DELAY=4 -> start rises exactly 4 cycles after the go edge; status=0 and all counters 0 before that.
- 10 commits of non-halt instructions, then a commit of 0x00100073 with reg_a0=0 -> next cycle done=1, status=1, exit_code=0, instret_cnt=11, last_pc=halt pc, start=0.
- Halt committed with reg_a0=0x2A -> status=2, exit_code=0x2A.
- TIMEOUT_CYCLES=50, commit every 2 cycles, no halt -> done after the 50th RUN cycle, status=3, cycle_cnt=50, instret_cnt=25.
- STALL_LIMIT=8, commits stop -> status=4 after 8 idle RUN cycles. Variant: halt commit in the same cycle the stall or timeout limit is hit -> status=1.
- Assert reset for 1 cycle mid-RUN -> start=0 without waiting for a clock edge, state IDLE, counters 0. Then clear in DONE -> IDLE, and a new go reruns with fresh counters.
